// File: rtl/satatx_crc_pkg.sv
// satatx_crc_pkg: SATA CRC-32 constants, per-dword step function and the TX CRC state enum.
package satatx_crc_pkg;
    localparam logic [31:0] CRC_POLY = 32'h04c11db7;
    localparam logic [31:0] CRC_INIT = 32'h52325032;

    typedef enum logic {DATA, CRC} state_t;

    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [31:0] dword,
                                             input logic [31:0] poly);
        logic [31:0] c;
        c = crc ^ dword;
        for (int i = 0; i < 32; i++)
            c = c[31] ? {c[30:0], 1'b0} ^ poly : {c[30:0], 1'b0};
        return c;
    endfunction
endpackage

// File: rtl/satacrc_step.sv
// satacrc_step: combinational one-dword SATA CRC-32 update, shared by the TX and RX CRC paths.
module satacrc_step
    import satatx_crc_pkg::*;
#(
    parameter logic [31:0] POLYNOMIAL = CRC_POLY
) (
    input  logic [31:0] crc,
    input  logic [31:0] dword,
    output logic [31:0] crc_next
);
    assign crc_next = crc_step(crc, dword, POLYNOMIAL);
endmodule

// File: rtl/satatx_crc.sv
// satatx_crc: SATA TX CRC-32 append stage; i_abort port exists only with SATATX_CRC_ABORT_EN.
module satatx_crc
    import satatx_crc_pkg::*;
#(
    parameter logic [31:0] POLYNOMIAL   = CRC_POLY,
    parameter logic [31:0] INITIAL      = CRC_INIT,
    parameter logic        OPT_LOWPOWER = 1'b1
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESET,
    input  logic        S_AXIS_TVALID,
    output logic        S_AXIS_TREADY,
    input  logic [31:0] S_AXIS_TDATA,
    input  logic        S_AXIS_TLAST,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TLAST
`ifdef SATATX_CRC_ABORT_EN
    ,
    input  logic        i_abort
`endif
);
    state_t      state, next_state;
    logic [31:0] crc, crc_next;
    logic        abort, out_free, accept;

`ifdef SATATX_CRC_ABORT_EN
    assign abort = i_abort;
`else
    assign abort = 1'b0;
`endif

    assign out_free = !M_AXIS_TVALID || M_AXIS_TREADY;
    assign accept   = S_AXIS_TVALID && S_AXIS_TREADY;

    satacrc_step #(.POLYNOMIAL(POLYNOMIAL)) u_step (
        .crc      (crc),
        .dword    (S_AXIS_TDATA),
        .crc_next (crc_next)
    );

    always_ff @(posedge S_AXI_ACLK)
        state <= S_AXI_ARESET ? DATA : next_state;

    always_comb
        next_state = abort ? DATA
                   : state == DATA ? ((accept && S_AXIS_TLAST) ? CRC : DATA)
                   : (out_free ? DATA : CRC);

    always_comb
        S_AXIS_TREADY = state == DATA && out_free;

    // Abort shares the reset path for the datapath: the stalled beat and running CRC are dropped.
    always_ff @(posedge S_AXI_ACLK)
        if (S_AXI_ARESET || abort) begin
            crc           <= INITIAL;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TDATA  <= 32'h0;
            M_AXIS_TLAST  <= 1'b0;
        end else if (state == CRC) begin
            if (out_free) begin
                M_AXIS_TDATA  <= crc;
                M_AXIS_TLAST  <= 1'b1;
                M_AXIS_TVALID <= 1'b1;
                crc           <= INITIAL;
            end
        end else if (accept) begin
            M_AXIS_TDATA  <= S_AXIS_TDATA;
            M_AXIS_TLAST  <= 1'b0;
            M_AXIS_TVALID <= 1'b1;
            crc           <= crc_next;
        end else if (M_AXIS_TREADY) begin
            M_AXIS_TVALID <= 1'b0;
            if (OPT_LOWPOWER) begin
                M_AXIS_TDATA <= 32'h0;
                M_AXIS_TLAST <= 1'b0;
            end
        end
endmodule

// File: tb/tb_satatx_crc.sv
// tb_satatx_crc: directed vectors, reset/abort sequences and randomized backpressure for satatx_crc.
module tb_satatx_crc;
    logic        clk = 1'b0, rst = 1'b1;
    logic        s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1;
    logic [31:0] s_data = 32'h0;
    logic        s_ready, m_valid, m_last, s1_ready, m1_valid, m1_last;
    logic [31:0] m_data, m1_data;
    int          checks = 0, failures = 0;
`ifdef SATATX_CRC_ABORT_EN
    logic        abort = 1'b0;
`endif

    always #5 clk = ~clk;

    satatx_crc dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXIS_TVALID(s_valid), .S_AXIS_TREADY(s_ready), .S_AXIS_TDATA(s_data), .S_AXIS_TLAST(s_last),
        .M_AXIS_TVALID(m_valid), .M_AXIS_TREADY(m_ready), .M_AXIS_TDATA(m_data), .M_AXIS_TLAST(m_last)
`ifdef SATATX_CRC_ABORT_EN
        , .i_abort(abort)
`endif
    );

    satatx_crc #(.INITIAL(32'h0)) dut_z (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXIS_TVALID(s_valid), .S_AXIS_TREADY(s1_ready), .S_AXIS_TDATA(s_data), .S_AXIS_TLAST(s_last),
        .M_AXIS_TVALID(m1_valid), .M_AXIS_TREADY(m_ready), .M_AXIS_TDATA(m1_data), .M_AXIS_TLAST(m1_last)
`ifdef SATATX_CRC_ABORT_EN
        , .i_abort(abort)
`endif
    );

    typedef struct {
        logic [31:0] d;
        logic        chk0;
        logic [31:0] exp0;
        logic        chk1;
        logic [31:0] exp1;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } beat_t;

    vec_t        vecs[6];
    beat_t       exp_q[$];
    logic [31:0] cur[$];

    // Reference: long division of (crc ^ d) * x^32 by the generator.
    function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [31:0] d);
        logic [63:0] r;
        r = {c ^ d, 32'h0};
        for (int i = 63; i >= 32; i--)
            if (r[i]) r = r ^ (64'({1'b1, 32'h04c11db7}) << (i - 32));
        return r[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic frame1(input logic [31:0] d, input logic chk0, input logic [31:0] exp0,
                          input logic chk1, input logic [31:0] exp1);
        s_valid = 1'b1; s_data = d; s_last = 1'b1; m_ready = 1'b1;
        tick;
        s_valid = 1'b0; s_last = 1'b0;
        #1;
        check("payload_valid", m_valid, 1);
        check("payload_data", m_data, d);
        check("payload_last", m_last, 0);
        check("crc_stall_ready", s_ready, 0);
        tick;
        check("crc_valid", m_valid, 1);
        check("crc_last", m_last, 1);
        if (chk0) check("crc_data", m_data, exp0);
        if (chk1) check("crc_data_init0", m1_data, exp1);
        tick;
        check("idle_valid", m_valid, 0);
        check("idle_data", m_data, 0);
    endtask

    initial begin
        int          nf, cyc, len;
        logic        stalled, sl, s_hs;
        logic [31:0] sd, crc;
        beat_t       b;

        vecs[0] = '{32'h52325033, 1'b1, 32'h04c11db7, 1'b0, 32'h0};
        vecs[1] = '{32'h52325032, 1'b1, 32'h00000000, 1'b0, 32'h0};
        vecs[2] = '{32'h00000001, 1'b0, 32'h0, 1'b1, 32'h04c11db7};
        vecs[3] = '{32'h00000000, 1'b0, 32'h0, 1'b1, 32'h00000000};
        vecs[4] = '{32'h52325031, 1'b1, 32'h0d4326d9, 1'b0, 32'h0};
        vecs[5] = '{32'h52325036, 1'b1, 32'h130476dc, 1'b1, ref_crc(32'h0, 32'h52325036)};

        tick; tick;
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_last", m_last, 0);
        check("rst_ready", s_ready, 1);
        rst = 1'b0;
        tick;

        for (int i = 0; i < 6; i++)
            frame1(vecs[i].d, vecs[i].chk0, vecs[i].exp0, vecs[i].chk1, vecs[i].exp1);

        // Reset lands on the third of five dwords.
        s_valid = 1'b1; m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_data = 32'h1000 + k; s_last = 1'b0;
            if (k == 2) rst = 1'b1;
            tick;
        end
        check("midrst_valid", m_valid, 0);
        check("midrst_data", m_data, 0);
        check("midrst_last", m_last, 0);
        rst = 1'b0; s_valid = 1'b0;
        tick;
        check("midrst_ready", s_ready, 1);
        frame1(32'h52325033, 1'b1, 32'h04c11db7, 1'b0, 32'h0);

`ifdef SATATX_CRC_ABORT_EN
        s_valid = 1'b1; s_data = 32'h52325033; s_last = 1'b1; m_ready = 1'b0;
        tick;
        s_valid = 1'b0; s_last = 1'b0;
        tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("abort_valid", m_valid, 0);
        m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            check("abort_no_crc", m_valid, 0);
        end
        frame1(32'h52325033, 1'b1, 32'h04c11db7, 1'b0, 32'h0);
`endif

        nf = 0; cyc = 0; stalled = 1'b0; sd = 32'h0; sl = 1'b0;
        while ((nf < 1000 || cur.size() > 0 || exp_q.size() > 0) && cyc < 90000) begin
            if (cur.size() == 0 && nf < 1000) begin
                len = $urandom_range(1, 64);
                crc = 32'h52325032;
                for (int k = 0; k < len; k++) begin
                    b.d = $urandom; b.l = 1'b0;
                    cur.push_back(b.d);
                    exp_q.push_back(b);
                    crc = ref_crc(crc, b.d);
                end
                b.d = crc; b.l = 1'b1;
                exp_q.push_back(b);
                nf++;
            end
            s_valid = cur.size() > 0;
            s_data  = s_valid ? cur[0] : 32'h0;
            s_last  = cur.size() == 1;
            m_ready = $urandom_range(0, 3) != 0;
            #1;
            if (stalled) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, sd);
                check("stall_last", m_last, sl);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL extra_beat: got %h with no beat expected", m_data);
                end else begin
                    b = exp_q.pop_front();
                    check("rand_data", m_data, b.d);
                    check("rand_last", m_last, b.l);
                end
            end
            stalled = m_valid && !m_ready;
            sd = m_data; sl = m_last;
            s_hs = s_valid && s_ready;
            tick;
            cyc++;
            if (s_hs) void'(cur.pop_front());
        end
        if (cyc >= 90000) begin
            checks++; failures++;
            $display("FAIL rand_timeout: %0d beats outstanding after %0d cycles", exp_q.size(), cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
